crc8_rx_checker: RTL and testbench
==================================

// Module: crc8_rx_checker
// PURPOSE
// - Receive-side CRC-8 checker: the far end of the error-injection path. Consumes a
//   byte stream framed by sof/eof (last byte of each frame = transmitted CRC), runs
//   a parallel byte-wide CRC-8 over the payload and flags each frame good or bad.
// - Sits downstream of the error injector and bit-flip channel in the link test
//   harness. Drives pass/fail status and frame statistics to the bench/scoreboard.
// PARAMETERS
// - POLY     8'h07  CRC-8 generator polynomial (x^8+x^2+x+1), MSB-first, no reflection
// - INIT     8'h00  CRC register value loaded at start of frame
// - MAX_LEN  64     max bytes per frame incl. CRC byte; longer frame -> abort
// - CNT_W    16     width of frame/error statistics counters
// PORTS
// - clk        in   1      system clock, all logic on rising edge
// - reset      in   1      synchronous, active-high reset
// - data_in    in   8      received byte
// - data_valid in   1      data_in valid this cycle; no backpressure, accepted always
// - sof        in   1      qualifies first byte of frame (only when data_valid=1)
// - eof        in   1      qualifies last byte = received CRC (only when data_valid=1)
// - done       out  1      1-cycle pulse: frame verdict valid
// - crc_ok     out  1      verdict: received CRC == computed CRC (held until next done)
// - crc_err    out  1      verdict: mismatch (held until next done); never =crc_ok=1
// - crc_calc   out  8      computed payload CRC of last completed frame
// - abort      out  1      1-cycle pulse: frame discarded (restart or overlength)
// - frame_cnt  out  CNT_W  completed frames (wraps)
// - err_cnt    out  CNT_W  CRC-mismatch frames (see CONFIGURATION)
// BEHAVIOUR
// - Reset (sync): FSM->IDLE, crc reg=INIT, len=0; all outputs 0. Reset mid-frame
//   discards the frame silently (no done, no abort).
// - FSM states: IDLE, RUN.
//   IDLE: data_valid&sof&~eof -> RUN, crc=next(INIT,data_in), len=1.
//         data_valid&sof&eof -> zero-payload frame: compare data_in against INIT.
//         Any byte without sof ignored (stray/eof-only bytes dropped, no flags).
//   RUN:  data_valid&~sof&~eof -> crc=next(crc,data_in), len++.
//         data_valid&eof&~sof -> compare data_in vs crc, -> IDLE.
//         data_valid&sof (eof or not) -> abort pulse, restart as if from IDLE on this byte.
//         len reaching MAX_LEN without eof -> abort pulse, -> IDLE, rest ignored until sof.
//         data_valid=0 -> hold state, no update (gaps allowed anywhere).
// - next(c,d): 8 serial shift steps unrolled combinationally: per bit b=7..0,
//   fb=c[7]^d[b]; c={c[6:0],1'b0}^(fb?POLY:0). One byte per cycle, no stalls.
// - Verdict latency: done/crc_ok/crc_err/crc_calc/frame_cnt update on the clock edge
//   after the eof byte is sampled (1-cycle latency). Back-to-back frames
//   (eof then sof next cycle) fully supported.
// - abort does not change crc_ok/crc_err/crc_calc or counters.
// - Counters: frame_cnt increments on every done; err_cnt per CONFIGURATION. Both
//   wrap at 2^CNT_W unless stated otherwise.
// CONFIGURATION
// - `CRC8_ERR_SAT_EN defined: err_cnt increments on crc_err and saturates at
//   all-ones (no wrap); frame_cnt unaffected (still wraps).
// - Not defined: err_cnt increments on crc_err and wraps like frame_cnt.
// TESTING
// - Payload "123456789" (0x31..0x39) + CRC 0xF4 -> done 1 cycle after eof,
//   crc_calc=F4, crc_ok=1, frame_cnt=1.
// - Payload 0x01 + CRC 0x06 (true 0x07, LSB flipped by injector) -> crc_err=1,
//   crc_calc=07, err_cnt=1.
// - sof&eof single byte 0x00 -> crc_ok; single byte 0x5A -> crc_err.
// - sof at 0x31, 0x32, then sof again mid-frame -> abort pulse; new frame
//   0x01+0x07 -> crc_ok; 65 bytes with no eof (MAX_LEN=64) -> abort, no done.
// - Random data_valid gaps inside "123456789" frame -> same result as case 1;
//   reset asserted mid-frame -> all outputs 0, next frame checks correctly.
// - With CRC8_ERR_SAT_EN, CNT_W=2: 5 bad frames -> err_cnt=3; without: err_cnt=1.

Source files
------------

// File: rtl/crc8_rx_checker.sv
// Receive-side CRC-8 checker: consumes sof/eof framed bytes (last byte = CRC), flags each frame.
// Optional `CRC8_ERR_SAT_EN makes err_cnt saturate at all-ones instead of wrapping.
module crc8_rx_checker #(
  parameter logic [7:0] POLY    = 8'h07,
  parameter logic [7:0] INIT    = 8'h00,
  parameter int         MAX_LEN = 64,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             sof,
  input  logic             eof,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [7:0]       crc_calc,
  output logic             abort,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             state_dbg
);

  // Handshake: a byte is consumed on every rising edge where data_valid=1; there is no
  // backpressure. done/abort are single-cycle pulses, the verdict fields hold until the next done.

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [7:0]       crc;
  logic [LEN_W-1:0] len;

  // MSB-first CRC-8 byte update: eight serial shift steps unrolled.
  function automatic logic [7:0] crc8_next(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ d[b];
      c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
    return c;
  endfunction

  logic [7:0] crc_from_init;
  logic [7:0] crc_from_run;

  assign crc_from_init = crc8_next(INIT, data_in);
  assign crc_from_run  = crc8_next(crc, data_in);
  assign state_dbg     = (state == RUN);

  logic       verdict_fire;
  logic [7:0] verdict_calc;
  logic       start_frame;
  logic       abort_now;
  logic       extend;
  logic       overlen;

  always_comb begin
    verdict_fire = 1'b0;
    verdict_calc = crc;
    start_frame  = 1'b0;
    abort_now    = 1'b0;
    extend       = 1'b0;
    overlen      = 1'b0;
    if (data_valid) begin
      case (state)
        IDLE: begin
          if (sof) begin
            if (eof) begin
              verdict_fire = 1'b1;
              verdict_calc = INIT;
            end else begin
              start_frame = 1'b1;
            end
          end
        end
        RUN: begin
          if (sof) begin
            // A new sof discards the open frame and is then handled as if seen in IDLE.
            abort_now = 1'b1;
            if (eof) begin
              verdict_fire = 1'b1;
              verdict_calc = INIT;
            end else begin
              start_frame = 1'b1;
            end
          end else if (eof) begin
            verdict_fire = 1'b1;
            verdict_calc = crc;
          end else if (len == LEN_W'(MAX_LEN - 1)) begin
            abort_now = 1'b1;
            overlen   = 1'b1;
          end else begin
            extend = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      crc       <= INIT;
      len       <= '0;
      done      <= 1'b0;
      abort     <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      crc_calc  <= 8'h00;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      done  <= verdict_fire;
      abort <= abort_now;

      if (verdict_fire) begin
        crc_calc  <= verdict_calc;
        crc_ok    <= (data_in == verdict_calc);
        crc_err   <= (data_in != verdict_calc);
        frame_cnt <= frame_cnt + CNT_W'(1);
        if (data_in != verdict_calc) begin
`ifdef CRC8_ERR_SAT_EN
          if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
`else
          err_cnt <= err_cnt + CNT_W'(1);
`endif
        end
      end

      if (start_frame) begin
        state <= RUN;
        crc   <= crc_from_init;
        len   <= LEN_W'(1);
      end else if (verdict_fire || overlen) begin
        state <= IDLE;
        crc   <= INIT;
        len   <= '0;
      end else if (extend) begin
        crc <= crc_from_run;
        len <= len + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_crc8_rx_checker.sv
// Bench for crc8_rx_checker: directed framing cases then randomized frames against a
// polynomial-division reference model; a posedge monitor pops verdicts from a scoreboard.
module tb_crc8_rx_checker;

  localparam int         CNT_W   = 4;
  localparam int         MAX_LEN = 64;
  localparam logic [7:0] POLY    = 8'h07;
  localparam int         VW      = 2 + 8 + 2 * CNT_W;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             sof;
  logic             eof;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic [7:0]       crc_calc;
  logic             abort;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             state_dbg;

  crc8_rx_checker #(.POLY(POLY), .INIT(8'h00), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .sof(sof),
    .eof(eof), .done(done), .crc_ok(crc_ok), .crc_err(crc_err), .crc_calc(crc_calc),
    .abort(abort), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_status = '0;
  int exp_abort_total = 0;
  int obs_abort_total = 0;

  // reference model
  byte_q_t m_payload;
  bit      m_in_frame = 1'b0;
  int      m_frames = 0;
  int      m_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remainder of payload(x) * x^8 divided by the 9-bit generator, bit by bit.
  function automatic logic [7:0] crc_of(input byte_q_t q);
    logic [8:0] rem;
    logic       bitv;
    rem = '0;
    for (int i = 0; i < q.size() + 1; i++) begin
      for (int b = 7; b >= 0; b--) begin
        bitv = (i < q.size()) ? q[i][b] : 1'b0;
        rem  = {rem[7:0], bitv};
        if (rem[8]) rem = rem ^ {1'b1, POLY};
      end
    end
    return rem[7:0];
  endfunction

  task automatic model_verdict(input logic [7:0] rx);
    logic [7:0]       calc;
    logic             ok;
    logic [CNT_W-1:0] fc;
    logic [CNT_W-1:0] ec;
    calc = crc_of(m_payload);
    ok   = (calc == rx);
    m_frames++;
    if (!ok) m_errs++;
    fc = CNT_W'(m_frames % (CNT_MAX + 1));
`ifdef CRC8_ERR_SAT_EN
    ec = CNT_W'((m_errs > CNT_MAX) ? CNT_MAX : m_errs);
`else
    ec = CNT_W'(m_errs % (CNT_MAX + 1));
`endif
    exp_q.push_back({ok, ~ok, calc, fc, ec});
    m_in_frame = 1'b0;
    m_payload.delete();
  endtask

  task automatic model_byte(input logic [7:0] d, input logic s, input logic e);
    if (s) begin
      if (m_in_frame) exp_abort_total++;
      m_payload.delete();
      m_in_frame = 1'b1;
      if (e) model_verdict(d);
      else m_payload.push_back(d);
    end else if (m_in_frame) begin
      if (e) begin
        model_verdict(d);
      end else begin
        m_payload.push_back(d);
        if (m_payload.size() == MAX_LEN) begin
          exp_abort_total++;
          m_in_frame = 1'b0;
          m_payload.delete();
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    @(negedge clk);
    data_in    = d;
    sof        = s;
    eof        = e;
    data_valid = 1'b1;
    model_byte(d, s, e);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      data_valid = 1'b0;
      data_in    = 8'($urandom);
      sof        = 1'($urandom_range(0, 1));
      eof        = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input byte_q_t pl, input logic [7:0] crc, input int gap_max);
    for (int i = 0; i < pl.size(); i++) begin
      if (gap_max > 0) gap($urandom_range(0, gap_max));
      send_byte(pl[i], (i == 0), 1'b0);
    end
    if (gap_max > 0) gap($urandom_range(0, gap_max));
    send_byte(crc, (pl.size() == 0), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    data_valid = 1'b0;
    m_in_frame = 1'b0;
    m_payload.delete();
    m_frames   = 0;
    m_errs     = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (reset) begin
      exp_status = '0;
      check("reset_outputs", 32'({done, abort, crc_ok, crc_err, crc_calc, frame_cnt, err_cnt}), 32'd0);
    end else begin
      if (done) begin
        if (exp_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
        else exp_status = exp_q.pop_front();
      end
      if (abort) begin
        obs_abort_total++;
        if (obs_abort_total > exp_abort_total) check("abort_unexpected", 32'(obs_abort_total), 32'(exp_abort_total));
      end
      check("status", 32'({crc_ok, crc_err, crc_calc, frame_cnt, err_cnt}), 32'(exp_status));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    byte_q_t q;
    logic [7:0] c;
    int kind;
    int n;

    reset      = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    sof        = 1'b0;
    eof        = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    gap(2);

    // "123456789" check value
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    send_frame(q, 8'hF4, 0);
    gap(2);
    check("check_value_calc", 32'(crc_calc), 32'h F4);
    check("check_value_ok", 32'({crc_ok, crc_err}), 32'b10);
    check("check_value_frames", 32'(frame_cnt), 32'd1);

    // single-bit corrupted CRC
    q.delete();
    q.push_back(8'h01);
    send_frame(q, 8'h06, 0);
    gap(2);
    check("flip_err", 32'({crc_ok, crc_err}), 32'b01);
    check("flip_calc", 32'(crc_calc), 32'h07);
    check("flip_err_cnt", 32'(err_cnt), 32'd1);

    // zero-payload frames
    send_byte(8'h00, 1'b1, 1'b1);
    gap(2);
    check("zero_payload_ok", 32'({crc_ok, crc_err}), 32'b10);
    send_byte(8'h5A, 1'b1, 1'b1);
    gap(2);
    check("zero_payload_err", 32'({crc_ok, crc_err}), 32'b01);

    // restart mid-frame
    send_byte(8'h31, 1'b1, 1'b0);
    send_byte(8'h32, 1'b0, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h07, 1'b0, 1'b1);
    gap(2);
    check("restart_abort", 32'(obs_abort_total), 32'd1);
    check("restart_ok", 32'({crc_ok, crc_err}), 32'b10);

    // overlength: 65 bytes, no eof
    for (int i = 0; i < 65; i++) send_byte(8'($urandom), (i == 0), 1'b0);
    gap(3);
    check("overlen_abort", 32'(obs_abort_total), 32'd2);
    check("overlen_no_done", 32'(frame_cnt), 32'd5);

    // gaps inside the check-value frame
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    send_frame(q, 8'hF4, 3);
    gap(2);
    check("gapped_calc", 32'(crc_calc), 32'hF4);
    check("gapped_frames", 32'(frame_cnt), 32'd6);

    // reset mid-frame
    send_byte(8'h31, 1'b1, 1'b0);
    send_byte(8'h32, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    do_reset();
    check("mid_reset_frames", 32'(frame_cnt), 32'd0);
    q.delete();
    q.push_back(8'h01);
    send_frame(q, 8'h07, 0);
    gap(2);
    check("post_reset_ok", 32'({crc_ok, crc_err, crc_calc}), 32'({2'b10, 8'h07}));
    check("post_reset_frames", 32'(frame_cnt), 32'd1);

    // randomized traffic
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        n = $urandom_range(0, 5);
        for (int i = 0; i <= n; i++) send_byte(8'($urandom), (i == 0), 1'b0);
      end else if (kind == 2) begin
        n = $urandom_range(64, 66);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), (i == 0), 1'b0);
        send_byte(8'($urandom), 1'b0, 1'b1);
      end else begin
        q.delete();
        n = (kind == 3) ? $urandom_range(55, 63) : $urandom_range(0, 20);
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        c = crc_of(q);
        if ($urandom_range(0, 2) == 0) c = c ^ (8'h01 << $urandom_range(0, 7));
        send_frame(q, c, $urandom_range(0, 2));
      end
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
    end

    gap(4);
    check("pending_verdicts", 32'(exp_q.size()), 32'd0);
    check("abort_total", 32'(obs_abort_total), 32'(exp_abort_total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
